micro_sequencer: RTL

MICRO_SEQUENCER -- requirements
Module: micro_sequencer

---
 rtl/ms_pkg.sv | 24 ++
 rtl/ms_stack.sv | 52 +++++
 rtl/micro_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/ms_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ms_pkg
// Shared encodings and defaults for the micro_sequencer block.
// Revision: 1.0
// ---------------------------------------------------------------------------
package ms_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int COND_MOC   = 1;

   typedef enum logic [2:0] {
      ENC  = 3'b000,
      INC  = 3'b001,
      JMP  = 3'b010,
      CJMP = 3'b011,
      WAIT = 3'b100,
      CENC = 3'b101,
      CALL = 3'b110,
      RET  = 3'b111
   } n_mode_t;

endpackage
`default_nettype wire

// File: rtl/ms_stack.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ms_stack
// LIFO return stack; a push while full overwrites the top entry.
// Revision: 1.0
// ---------------------------------------------------------------------------
module ms_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_sp;
   logic [IDX_W-1:0] w_top_idx;
   logic [IDX_W-1:0] w_wr_idx;

   assign full      = (r_sp == PTR_W'(DEPTH));
   assign empty     = (r_sp == '0);
   assign w_top_idx = IDX_W'(r_sp - PTR_W'(1));
   assign w_wr_idx  = full ? w_top_idx : IDX_W'(r_sp);
   assign dout      = empty ? '0 : r_mem[w_top_idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sp <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (push) begin
         r_mem[w_wr_idx] <= din;
         if (!full) begin
            r_sp <= r_sp + PTR_W'(1);
         end
      end else if (pop && !empty) begin
         r_sp <= r_sp - PTR_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: rtl/micro_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// micro_sequencer
// Next-microaddress sequencer; optional return stack under MS_RETURN_STACK_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module micro_sequencer
   import ms_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int STACK_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        n,
   input  logic              inv,
   input  logic [2:0]        s,
   input  logic [ADDR_W-1:0] cr,
   input  logic [7:0]        cond,
   input  logic [ADDR_W-1:0] enc_addr,
   input  logic              halt,
   output logic [ADDR_W-1:0] upc,
   output logic              stack_err
);

   logic [ADDR_W-1:0] r_upc;
   logic [ADDR_W-1:0] w_upc_next;
   logic [ADDR_W-1:0] w_upc_inc;
   logic [ADDR_W-1:0] w_ret_addr;
   logic [7:0]        w_cond;
   logic              w_cnd;

   // Source 0 is the always-true condition, so the external bit is discarded.
   assign w_cond    = {cond[7:1], 1'b1};
   assign w_cnd     = w_cond[s] ^ inv;
   assign w_upc_inc = r_upc + ADDR_W'(1);
   assign upc       = r_upc;

`ifdef MS_RETURN_STACK_EN
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   logic [ADDR_W-1:0] w_stack_dout;
   logic              r_stack_err;
   logic              w_unused;

   assign w_unused   = &{1'b0, cond[0]};
   assign w_push     = !halt && (n == CALL);
   assign w_pop      = !halt && (n == RET);
   assign w_ret_addr = w_empty ? '0 : w_stack_dout;
   assign stack_err  = r_stack_err;

   ms_stack #(
      .WIDTH (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .clk   (clk),
      .reset (reset),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_upc_inc),
      .dout  (w_stack_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stack_err <= 1'b0;
      end else if ((w_push && w_full) || (w_pop && w_empty)) begin
         r_stack_err <= 1'b1;
      end
   end
`else
   logic w_unused;

   assign w_unused   = &{1'b0, cond[0], STACK_DEPTH[0]};
   assign w_ret_addr = '0;
   assign stack_err  = 1'b0;
`endif

   always_comb begin
      w_upc_next = w_upc_inc;
      case (n_mode_t'(n))
         ENC:     w_upc_next = enc_addr;
         INC:     w_upc_next = w_upc_inc;
         JMP:     w_upc_next = cr;
         CJMP:    w_upc_next = w_cnd ? cr : w_upc_inc;
         WAIT:    w_upc_next = w_cnd ? w_upc_inc : r_upc;
         CENC:    w_upc_next = w_cnd ? cr : enc_addr;
         CALL:    w_upc_next = cr;
         RET:     w_upc_next = w_ret_addr;
         default: w_upc_next = w_upc_inc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_upc <= '0;
      end else if (!halt) begin
         r_upc <= w_upc_next;
      end
   end

endmodule
`default_nettype wire
